// File: rtl/fwrisc_mds_iter_pkg.sv
// Op codes and FSM state type shared by the iterative multiply/divide/shift unit.
package fwrisc_mds_pkg;

    localparam logic [3:0] OP_SLL     = 4'd0;
    localparam logic [3:0] OP_SRL     = 4'd1;
    localparam logic [3:0] OP_SRA     = 4'd2;
    localparam logic [3:0] OP_MUL     = 4'd3;
    localparam logic [3:0] OP_MULH    = 4'd4;
    localparam logic [3:0] OP_MULHSU  = 4'd5;
    localparam logic [3:0] OP_MULHU   = 4'd6;
    localparam logic [3:0] OP_DIV     = 4'd7;
    localparam logic [3:0] OP_DIVU    = 4'd8;
    localparam logic [3:0] OP_REM     = 4'd9;
    localparam logic [3:0] OP_REMU    = 4'd10;
    localparam logic [3:0] OP_NUM_MDS = 4'd11;

    typedef enum logic [2:0] {IDLE, SHIFT, MUL, DIV, DONE} mds_state_e;

endpackage

// File: rtl/fwrisc_mds_iter_if.sv
// Exec <-> MDS unit handshake: op request in, single-cycle result pulse out.
interface fwrisc_mds_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [5:0]  in_rd;
    logic        out_valid;
    logic [31:0] out_data;
    logic [5:0]  out_rd;

    modport master (output in_valid, in_op, in_a, in_b, in_rd,
                    input  in_ready, out_valid, out_data, out_rd);
    modport slave  (input  in_valid, in_op, in_a, in_b, in_rd,
                    output in_ready, out_valid, out_data, out_rd);
endinterface

// File: rtl/fwrisc_mds_divstep.sv
// One restoring-division step: shift next dividend bit into rem, subtract divisor if it fits.
// Latency: combinational.
// Backpressure: none.
module fwrisc_mds_divstep (
    input  logic [31:0] rem,
    input  logic [31:0] quot,
    input  logic [31:0] divisor,
    output logic [31:0] rem_nxt,
    output logic [31:0] quot_nxt
);
    logic [32:0] shifted;
    logic [32:0] diff;

    // rem < divisor on entry, so diff lies in (-2^32, 2^32) and bit 32 is its sign
    always_comb begin
        shifted = {rem, quot[31]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[32]) begin
            rem_nxt  = diff[31:0];
            quot_nxt = {quot[30:0], 1'b1};
        end else begin
            rem_nxt  = shifted[31:0];
            quot_nxt = {quot[30:0], 1'b0};
        end
    end
endmodule

// File: rtl/fwrisc_mds_iter.sv
// Iterative MDS unit: shifts 1 bit/cycle, multiply/divide 32 steps, one op in flight.
// Latency: shamt+1 for shifts, 33 for mul/div, 1 for trivial divide cases and bad ops.
// Backpressure: in_ready only in IDLE; out_valid is a 1-cycle pulse with no stall.
module fwrisc_mds_iter
    import fwrisc_mds_pkg::*;
#(
    parameter bit ENABLE_DIV = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    fwrisc_mds_iter_if.slave mds
);
    mds_state_e  state_q, state_n;
    logic [3:0]  op_q, op_n;
    logic [4:0]  cnt_q, cnt_n;
    logic [63:0] acc_q, acc_n;
    logic [31:0] opb_q, opb_n;
    logic        neg_q, neg_n, rneg_q, rneg_n;
    logic [5:0]  rd_q, rd_n;
    logic [31:0] out_data_q, out_data_n;
    logic [5:0]  out_rd_q, out_rd_n;

    logic        in_sdiv, in_sa, in_sb;
    logic [31:0] in_ma, in_mb, imm_data;
    logic [31:0] sh_val, dv_rem, dv_quot, dv_q, dv_r;
    logic [32:0] mul_sum;
    logic [63:0] mul_acc, mul_prod;

    always_comb begin
        in_sdiv = (mds.in_op == OP_DIV) || (mds.in_op == OP_REM);
        in_sa   = mds.in_a[31] && (in_sdiv || mds.in_op == OP_MULH || mds.in_op == OP_MULHSU);
        in_sb   = mds.in_b[31] && (in_sdiv || mds.in_op == OP_MULH);
        in_ma   = in_sa ? -mds.in_a : mds.in_a;
        in_mb   = in_sb ? -mds.in_b : mds.in_b;
    end

    // acc[31:0] is the shift operand, {hi,multiplier} for MUL, {rem,quot} for DIV
    always_comb begin
        case (op_q)
            OP_SLL:  sh_val = {acc_q[30:0], 1'b0};
            OP_SRA:  sh_val = {acc_q[31], acc_q[31:1]};
            default: sh_val = {1'b0, acc_q[31:1]};
        endcase
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        mul_acc  = {mul_sum, acc_q[31:1]};
        mul_prod = neg_q ? -mul_acc : mul_acc;
        dv_q     = neg_q ? -dv_quot : dv_quot;
        dv_r     = rneg_q ? -dv_rem : dv_rem;
    end

    generate
        if (ENABLE_DIV) begin : g_div
            fwrisc_mds_divstep u_divstep (
                .rem      (acc_q[63:32]),
                .quot     (acc_q[31:0]),
                .divisor  (opb_q),
                .rem_nxt  (dv_rem),
                .quot_nxt (dv_quot)
            );
        end else begin : g_nodiv
            assign dv_rem  = '0;
            assign dv_quot = '0;
        end
    endgenerate

    always_comb begin
        state_n    = state_q;
        op_n       = op_q;
        cnt_n      = cnt_q;
        acc_n      = acc_q;
        opb_n      = opb_q;
        neg_n      = neg_q;
        rneg_n     = rneg_q;
        rd_n       = rd_q;
        out_data_n = out_data_q;
        out_rd_n   = out_rd_q;
        imm_data   = '0;
        case (state_q)
            IDLE: begin
                if (mds.in_valid) begin
                    op_n    = mds.in_op;
                    rd_n    = mds.in_rd;
                    cnt_n   = 5'd31;
                    neg_n   = in_sa ^ in_sb;
                    rneg_n  = in_sa;
                    state_n = DONE;
                    case (mds.in_op)
                        OP_SLL, OP_SRL, OP_SRA: begin
                            acc_n    = {32'd0, mds.in_a};
                            cnt_n    = mds.in_b[4:0];
                            imm_data = mds.in_a;
                            if (mds.in_b[4:0] != 5'd0) state_n = SHIFT;
                        end
                        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: begin
                            acc_n   = {32'd0, in_mb};
                            opb_n   = in_ma;
                            state_n = MUL;
                        end
                        OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                            if (!ENABLE_DIV) begin
                                imm_data = '0;
                            end else if (mds.in_b == 32'd0) begin
                                imm_data = (mds.in_op == OP_DIV || mds.in_op == OP_DIVU) ? '1 : mds.in_a;
                            end else if (in_sdiv && mds.in_a == 32'h8000_0000 && mds.in_b == 32'hFFFF_FFFF) begin
                                imm_data = (mds.in_op == OP_DIV) ? 32'h8000_0000 : 32'd0;
                            end else begin
                                acc_n   = {32'd0, in_ma};
                                opb_n   = in_mb;
                                state_n = DIV;
                            end
                        end
                        default: ;
                    endcase
                    // single-cycle ops publish their result now; iterative ones keep the old one
                    if (state_n == DONE) begin
                        out_data_n = imm_data;
                        out_rd_n   = mds.in_rd;
                    end
                end
            end
            SHIFT: begin
                acc_n = {32'd0, sh_val};
                cnt_n = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_n    = DONE;
                    out_data_n = sh_val;
                    out_rd_n   = rd_q;
                end
            end
            MUL: begin
                acc_n = mul_acc;
                cnt_n = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_n    = DONE;
                    out_data_n = (op_q == OP_MUL) ? mul_prod[31:0] : mul_prod[63:32];
                    out_rd_n   = rd_q;
                end
            end
            DIV: begin
                acc_n = {dv_rem, dv_quot};
                cnt_n = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_n    = DONE;
                    out_data_n = (op_q == OP_DIV || op_q == OP_DIVU) ? dv_q : dv_r;
                    out_rd_n   = rd_q;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            neg_q      <= 1'b0;
            rneg_q     <= 1'b0;
            rd_q       <= '0;
            out_data_q <= '0;
            out_rd_q   <= '0;
        end else begin
            state_q    <= state_n;
            op_q       <= op_n;
            cnt_q      <= cnt_n;
            acc_q      <= acc_n;
            opb_q      <= opb_n;
            neg_q      <= neg_n;
            rneg_q     <= rneg_n;
            rd_q       <= rd_n;
            out_data_q <= out_data_n;
            out_rd_q   <= out_rd_n;
        end
    end

    assign mds.in_ready  = (state_q == IDLE);
    assign mds.out_valid = (state_q == DONE);
    assign mds.out_data  = out_data_q;
    assign mds.out_rd    = out_rd_q;
endmodule

// File: tb/tb_fwrisc_mds_iter.sv
// Bench for fwrisc_mds_iter: arithmetic reference model checked every cycle plus directed cases.
module tb_fwrisc_mds_iter;
    import fwrisc_mds_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    fwrisc_mds_iter_if mds();

    fwrisc_mds_iter #(.ENABLE_DIV(1'b1)) dut (.clock(clock), .reset(reset), .mds(mds));

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        p;
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (op)
            OP_SLL:    return a << b[4:0];
            OP_SRL:    return a >> b[4:0];
            OP_SRA:    return sa >>> b[4:0];
            OP_MUL:    return a * b;
            OP_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            OP_MULHSU: begin p = {{32{a[31]}}, a} * {32'd0, b};       return p[63:32]; end
            OP_MULHU:  begin p = {32'd0, a} * {32'd0, b};             return p[63:32]; end
            OP_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            OP_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            OP_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            OP_REMU: return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op <= OP_SRA)   return int'(b[4:0]) + 1;
        if (op <= OP_MULHU) return 33;
        if (op <= OP_REMU) begin
            if (b == 32'd0) return 1;
            if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
        return 1;
    endfunction

    // Cycle-level expectation: one op in flight, result appears lat cycles after acceptance
    initial begin : monitor
        bit          busy = 1'b0, en = 1'b0, ev;
        int          cyc = 0, done_cyc = 0;
        logic [31:0] cur_d = '0, pend_d = '0;
        logic [5:0]  cur_rd = '0, pend_rd = '0;
        forever begin
            @(negedge clock);
            if (en) begin
                ev = busy && (cyc == done_cyc);
                if (ev) begin
                    cur_d  = pend_d;
                    cur_rd = pend_rd;
                end
                check("out_valid", 32'(mds.out_valid), 32'(ev));
                check("in_ready",  32'(mds.in_ready),  32'(!busy));
                check("out_data",  mds.out_data,       cur_d);
                check("out_rd",    32'(mds.out_rd),    32'(cur_rd));
            end
            if (reset) begin
                busy   = 1'b0;
                cur_d  = '0;
                cur_rd = '0;
                en     = 1'b1;
            end else if (en) begin
                if (busy && cyc == done_cyc) begin
                    busy = 1'b0;
                end else if (!busy && mds.in_valid) begin
                    busy     = 1'b1;
                    done_cyc = cyc + model_lat(mds.in_op, mds.in_a, mds.in_b);
                    pend_d   = model_res(mds.in_op, mds.in_a, mds.in_b);
                    pend_rd  = mds.in_rd;
                end
            end
            cyc++;
        end
    end

    task automatic wait_valid(output int k);
        for (k = 1; k <= 50; k++) begin
            @(negedge clock);
            if (mds.out_valid) break;
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] rd, input bit chk, input logic [31:0] exp_d,
                          input int exp_lat, input string nm);
        int k;
        @(posedge clock); #2;
        mds.in_valid = 1'b1;
        mds.in_op    = op;
        mds.in_a     = a;
        mds.in_b     = b;
        mds.in_rd    = rd;
        for (k = 0; k < 50; k++) begin
            @(negedge clock);
            if (mds.in_ready) break;
        end
        if (k >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_accept: in_ready never seen within 50 cycles", nm);
            mds.in_valid = 1'b0;
            return;
        end
        @(posedge clock); #2;
        mds.in_valid = 1'b0;
        wait_valid(k);
        if (chk) begin
            check({nm, "_lat"},  32'(k),           32'(exp_lat));
            check({nm, "_data"}, mds.out_data,     exp_d);
            check({nm, "_rd"},   32'(mds.out_rd),  32'(rd));
        end else if (k > 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: no out_valid within 50 cycles, expected one", nm);
        end
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin : stim
        int k;
        bit seen;
        mds.in_valid = 1'b0;
        mds.in_op    = '0;
        mds.in_a     = '0;
        mds.in_b     = '0;
        mds.in_rd    = '0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        check("rst_in_ready",  32'(mds.in_ready),  32'd1);
        check("rst_out_valid", 32'(mds.out_valid), 32'd0);
        check("rst_out_data",  mds.out_data,       32'd0);
        check("rst_out_rd",    32'(mds.out_rd),    32'd0);

        check("pin_mulhu", model_res(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        check("pin_rem",   model_res(OP_REM,   32'hFFFF_FFF9, 32'd2),         32'hFFFF_FFFF);
        check("pin_div",   model_res(OP_DIV,   32'hFFFF_FFF9, 32'd2),         32'hFFFF_FFFD);
        check("pin_sra",   model_res(OP_SRA,   32'h8000_0000, 32'h24),        32'hF800_0000);

        run_op(OP_SLL,    32'd1,         32'd31,        6'd1,  1'b1, 32'h8000_0000, 32, "sll31");
        run_op(OP_SRA,    32'h8000_0000, 32'h24,        6'd2,  1'b1, 32'hF800_0000, 5,  "sra4");
        run_op(OP_SRL,    32'h1234,      32'd0,         6'd3,  1'b1, 32'h1234,      1,  "srl0");
        run_op(OP_MUL,    32'hFFFF_FFFF, 32'd2,         6'd4,  1'b1, 32'hFFFF_FFFE, 33, "mul");
        run_op(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd5,  1'b1, 32'd0,         33, "mulh");
        run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd6,  1'b1, 32'hFFFF_FFFE, 33, "mulhu");
        run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'd3,         6'd7,  1'b1, 32'hFFFF_FFFF, 33, "mulhsu");
        run_op(OP_DIV,    32'd5,         32'd0,         6'd8,  1'b1, 32'hFFFF_FFFF, 1,  "div_by0");
        run_op(OP_REMU,   32'd5,         32'd0,         6'd9,  1'b1, 32'd5,         1,  "remu_by0");
        run_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 6'd10, 1'b1, 32'h8000_0000, 1,  "div_ovf");
        run_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 6'd11, 1'b1, 32'd0,         1,  "rem_ovf");
        run_op(OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 6'd12, 1'b1, 32'd0,         33, "divu_big");
        run_op(OP_REM,    32'hFFFF_FFF9, 32'd2,         6'd17, 1'b1, 32'hFFFF_FFFF, 33, "rem_m7");
        run_op(OP_DIV,    32'hFFFF_FFF9, 32'd2,         6'd18, 1'b1, 32'hFFFF_FFFD, 33, "div_m7");
        run_op(4'd13,     32'd123,       32'd456,       6'd19, 1'b1, 32'd0,         1,  "bad_op");

        // in_valid held high through a busy op: second op waits until the unit is idle again
        @(posedge clock); #2;
        mds.in_valid = 1'b1;
        mds.in_op    = OP_MUL;
        mds.in_a     = 32'hFFFF_FFFF;
        mds.in_b     = 32'd2;
        mds.in_rd    = 6'd20;
        @(negedge clock);
        check("b2b_ready", 32'(mds.in_ready), 32'd1);
        @(posedge clock); #2;
        mds.in_op = OP_DIV;
        mds.in_a  = 32'hFFFF_FFF9;
        mds.in_b  = 32'd2;
        mds.in_rd = 6'd21;
        wait_valid(k);
        check("b2b1_lat",  32'(k),          32'd33);
        check("b2b1_data", mds.out_data,    32'hFFFF_FFFE);
        check("b2b1_rd",   32'(mds.out_rd), 32'd20);
        @(negedge clock);
        check("b2b_ready_after_done", 32'(mds.in_ready), 32'd1);
        @(posedge clock); #2;
        mds.in_valid = 1'b0;
        wait_valid(k);
        check("b2b2_lat",  32'(k),          32'd33);
        check("b2b2_data", mds.out_data,    32'hFFFF_FFFD);
        check("b2b2_rd",   32'(mds.out_rd), 32'd21);

        // reset during a multiply: no result ever, idle right after reset
        @(posedge clock); #2;
        mds.in_valid = 1'b1;
        mds.in_op    = OP_MULHU;
        mds.in_a     = 32'h1234_5678;
        mds.in_b     = 32'h9ABC_DEF0;
        mds.in_rd    = 6'd33;
        @(negedge clock);
        @(posedge clock); #2;
        mds.in_valid = 1'b0;
        repeat (9) @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        check("rst_mid_ready", 32'(mds.in_ready), 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (mds.out_valid) seen = 1'b1;
        end
        check("rst_mid_no_valid", 32'(seen), 32'd0);

        for (int i = 0; i < 250; i++) begin
            run_op(4'($urandom_range(0, 12)), rnd_opnd(), rnd_opnd(),
                   6'($urandom_range(0, 63)), 1'b0, 32'd0, 0, "rnd");
        end

        repeat (3) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached before end of test");
        $fatal(1);
    end
endmodule
